vertex_scheduler: RTL

VERTEX_SCHEDULER -- requirements
Module: vertex_scheduler

---
 rtl/vertex_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/vertex_scheduler.sv
// Vertex fetch scheduler: issues vertex-buffer reads under a credit limit,
// forwards fetched positions to the transformation unit and buffers the
// transformed results in an in-order output FIFO with valid/ready handshake.
module vertex_scheduler #(
    parameter int ADDR_W       = 12,
    parameter int MAX_INFLIGHT = 4,
    parameter int RD_LAT       = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   vert_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [127:0]      mem_rdata,
    output logic              xf_v_in,
    output logic [127:0]      xf_pos,
    input  logic              xf_v_out,
    input  logic [127:0]      xf_new_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam logic [CW-1:0] CRED_MAX = CW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   issued;
    logic [ADDR_W:0]   popped;
    logic [CW-1:0]     credits;
    logic [RD_LAT-1:0] rd_dly;

    logic [127:0]      fifo_mem [MAX_INFLIGHT];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     fifo_cnt;

    logic start_acc;
    logic issue;
    logic pop;
    logic push;
    logic fifo_full;
    logic xf_stray;
    logic overflow;

    assign start_acc = (state == S_IDLE) && start;
    assign issue     = (state == S_RUN) && (issued < count_q) && (credits != '0);
    assign pop       = out_valid && out_ready;
    assign fifo_full = (fifo_cnt == CRED_MAX);
    assign xf_stray  = xf_v_out && ((state == S_IDLE) || (state == S_DONE));
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign overflow  = xf_v_out && !xf_stray && fifo_full && !pop;
    assign push      = xf_v_out && !xf_stray && !overflow;

    assign xf_v_in   = rd_dly[RD_LAT-1];
    assign xf_pos    = mem_rdata;
    assign out_valid = (fifo_cnt != '0);
    assign out_data  = fifo_mem[rd_ptr];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and control outputs
    always_comb begin
        state_nx = state;
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        mem_rd   = issue;
        mem_addr = base_q + issued[ADDR_W-1:0];
        unique case (state)
            S_IDLE:  if (start) state_nx = (vert_count == '0) ? S_DONE : S_RUN;
            S_RUN:   if (issued == count_q) state_nx = S_DRAIN;
            S_DRAIN: if (popped == count_q) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Batch parameters, issue/pop counters and credit accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            count_q <= '0;
            issued  <= '0;
            popped  <= '0;
            credits <= CRED_MAX;
        end else if (start_acc) begin
            base_q  <= base_addr;
            count_q <= vert_count;
            issued  <= '0;
            popped  <= '0;
            credits <= CRED_MAX;
        end else begin
            if (issue) issued <= issued + 1'b1;
            if (pop)   popped <= popped + 1'b1;
            case ({issue, pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    // Read-strobe delay line aligning xf_v_in with returning memory data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dly <= '0;
        end else begin
            rd_dly[0] <= issue;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                rd_dly[i] <= rd_dly[i-1];
            end
        end
    end

    // Result FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Result FIFO storage
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= xf_new_pos;
    end

    // Sticky error: stray or overflowing results; cleared by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (xf_stray || overflow) begin
            err <= 1'b1;
        end else if (start_acc) begin
            err <= 1'b0;
        end
    end

endmodule
